// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte stream into a small FIFO,
// serialized LSB-first on ser_tx with a programmable, per-frame latched bit period.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for P cycles
// DATA  | eight data bits, LSB first, P cycles each
// STOP  | stop bit (high) for P cycles, then chain to next frame or idle
module uart_tx_fifo #(
  parameter int DEPTH       = 4,
  parameter int DEFAULT_DIV = 106
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_div_we,
  input  logic [31:0]              cfg_div_di,
  output logic [31:0]              cfg_div_do,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     ser_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_q;
  logic [31:0]   div_q, per_q, cnt_q, per_new;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_idx_q;
  logic          tx_q, tx_next;
  logic          push, pop, tc, shift_en, last_bit, have_data;

  assign per_new   = (div_q < 32'd2) ? 32'd2 : div_q;
  assign in_ready  = (level_q != FULL);
  assign push      = in_valid && in_ready;
  assign have_data = (level_q != '0);
  assign tc        = (cnt_q == 32'd0);

  assign ser_tx     = tx_q;
  assign busy       = (state_q != IDLE) || have_data;
  assign fifo_level = level_q;
  assign cfg_div_do = div_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:  if (have_data) state_next = START;
      START: if (tc) state_next = DATA;
      DATA:  if (tc && bit_idx_q == 3'd7) state_next = STOP;
      STOP:  if (tc) state_next = have_data ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop      = have_data && ((state_q == IDLE) || (state_q == STOP && tc));
    shift_en = tc && ((state_q == START) || (state_q == DATA && bit_idx_q != 3'd7));
    last_bit = tc && (state_q == DATA) && (bit_idx_q == 3'd7);
    tx_next  = tx_q;
    if (pop)           tx_next = 1'b0;
    else if (shift_en) tx_next = shreg_q[0];
    else if (last_bit) tx_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= 32'(DEFAULT_DIV);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      per_q     <= 32'd2;
      cnt_q     <= 32'd0;
      shreg_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      tx_q <= tx_next;
      if (cfg_div_we) div_q <= cfg_div_di;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // Period is captured at every start bit so a divider write never disturbs a live frame.
      if (pop) begin
        per_q     <= per_new;
        cnt_q     <= per_new - 32'd1;
        shreg_q   <= mem[rd_ptr];
        bit_idx_q <= 3'd0;
      end else if (state_q != IDLE) begin
        cnt_q <= tc ? per_q - 32'd1 : cnt_q - 32'd1;
        if (shift_en) begin
          shreg_q <= shreg_q >> 1;
          if (state_q == DATA) bit_idx_q <= bit_idx_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter for PicoSoC: accepts bytes over a valid/ready stream, queues them in a small FIFO, and serializes them LSB-first onto a single line with a programmable bit period. It is the transmitting end of the serial link the system bench decodes: idle high, one start bit, 8 data bits, one stop bit. It sits beside the existing UART register block and drives the board `ser_tx` pin.

## Interface

Parameters:

- `DEPTH`, 4: FIFO depth in bytes; a power of two, 2..16.
- `DEFAULT_DIV`, 106: bit period in `clk` cycles after reset.

Ports:

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `cfg_div_we`  in  1  write strobe for the divider register.
- `cfg_div_di`  in  32  new divider value.
- `cfg_div_do`  out  32  current divider register value.
- `in_valid`  in  1  byte offered.
- `in_ready`  out  1  FIFO can accept a byte.
- `in_data`  in  8  byte to send.
- `ser_tx`  out  1  serial line output, registered.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `fifo_level`  out  $clog2(DEPTH)+1  number of queued bytes, excluding the frame in flight.

## Operation

- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Push: on a rising edge with `in_valid && in_ready`, `in_data` is written to the FIFO tail.
- Handshake rules:
  - `in_ready` = (`fifo_level` != DEPTH), driven from registered state only.
  - `in_data` is sampled only on a handshake.
  - A source may hold `in_valid` high indefinitely.
- Divider:
  - `cfg_div_we` loads `cfg_div_di` into the divider register on the next edge.
  - The effective period `P` is max(div, 2).
  - `P` is latched at each start-bit edge, so a frame always completes with the period it began with.
- State machine (`IDLE`, `START`, `DATA`, `STOP`):
  - IDLE: `ser_tx`=1. If `fifo_level`>0 on an edge: pop the head into the shift register, latch `P`, drive `ser_tx`=0, go to START.
  - START: hold for `P` cycles, then drive data bit 0 and go to DATA.
  - DATA: each bit is held `P` cycles, shifting LSB first. After bit 7's `P` cycles, drive `ser_tx`=1 and go to STOP.
  - STOP: hold for `P` cycles. At its end, if `fifo_level`>0, pop and drive the next start bit on the same edge (back-to-back, no idle gap); otherwise go to IDLE.
- Counters: the bit-cycle counter is 32 bits and the bit index is 3 bits. Neither ever wraps inside a frame.
- Simultaneous push and pop on one edge: `fifo_level` is unchanged, and both pointers advance modulo DEPTH.
- `busy` = (state != IDLE) || (`fifo_level` != 0).

## Timing

- Reset values:
  - `ser_tx`=1, `in_ready`=1, `busy`=0, `fifo_level`=0, `cfg_div_do`=DEFAULT_DIV.
  - State is IDLE, pointers are 0, and the FIFO contents are discarded.
- Reset mid-frame: `ser_tx` returns to 1 on the reset edge. The partial frame and all queued bytes are dropped.
- Latency:
  - A byte accepted at edge E into an idle, empty transmitter produces the `ser_tx` falling edge at E+1.
  - `fifo_level` reads 1 after E and 0 after E+1.
- Frame length: exactly 10·`P` cycles from start-bit edge to the end of the stop bit. Each line transition lands exactly on a `P` boundary.
- Continuous stream: the byte rate is one per 10·`P` cycles, and `ser_tx` stays high for exactly `P` cycles between frames.
- Full FIFO: `in_ready` drops the cycle after the DEPTH-th byte is stored. It rises the cycle after the next pop.
- Divider write during a frame: the current frame is unaffected, and the next start bit uses the new `P`.
- `cfg_div_do` reflects a write on the cycle after `cfg_div_we`.

## Test plan

- Single byte at reset divider: push 0x41, with the serial decoder sampling at 53/106 cycles.
  - Decoder reports 'A'.
  - `ser_tx` is low for cycles 1..106 after the handshake, then follows bits 1,0,0,0,0,0,1,0 at 106 cycles each, then high.
- Back-to-back: push 0x55, 0xAA, 0x0D with `in_valid` held high.
  - Decoder gets three bytes in order.
  - Stop-bit high time is exactly 106 cycles between frames.
  - `busy` falls 3180 cycles after the first start edge.
- Backpressure (DEPTH=4, div=8): push 6 bytes continuously.
  - `in_ready` deasserts after 5 acceptances (1 in flight plus 4 queued) and re-asserts one cycle after each pop.
  - All 6 bytes arrive in order.
- Divider change and clamp: set div=20, then push 0x00. Mid-frame, write div=0, then push 0xFF.
  - First frame uses 20-cycle bits.
  - Second frame uses 2-cycle bits.
  - `cfg_div_do` reads 0.
- Reset mid-frame: assert `reset` during data bit 3 with 2 bytes queued.
  - `ser_tx`=1 on the next cycle, `fifo_level`=0, `in_ready`=1, `busy`=0.
  - No further start bit appears until a new push.
